// File: rtl/seq_detector_pkg.sv
// seq_detector_pkg
//   Shared definitions for the serial pattern detector: the fill-FSM state
//   encoding, the legal pattern-length range and the default pattern.
//   Optional feature macro used by the design: SEQDET_COUNT_EN.
package seq_detector_pkg;

  // FILL: fewer than PAT_LEN-1 valid history bits.
  // ARMED: history is full, so the next qualified bit can complete a match.
  typedef enum logic {
    FILL  = 1'b0,
    ARMED = 1'b1
  } fill_state_e;

  localparam int PAT_LEN_MIN     = 2;
  localparam int PAT_LEN_MAX     = 16;
  localparam int PAT_LEN_DEFAULT = 4;

  localparam logic [PAT_LEN_DEFAULT-1:0] PATTERN_DEFAULT = 4'b1011;

endpackage

// File: rtl/seq_detector_mealy_if.sv
// seq_detector_mealy_if
//   Groups the serial-input side of the detector.
//   Optional feature macro: SEQDET_COUNT_EN (adds match_cnt).
//   Signals:
//     en        input-bit qualifier (0 = bubble)
//     xin       serial data bit
//     overlap   1 = overlapping matches allowed
//     pat_load  load pat_in into the pattern register
//     pat_in    new pattern, MSB = first bit received
//     zout      Mealy match output (combinational)
//     match_cnt saturating match count (SEQDET_COUNT_EN only)
//   Modports: master drives the stream, slave is the detector.
interface seq_detector_mealy_if #(
  parameter int PAT_LEN = 4,
  parameter int CNT_W   = 8
);

  logic               en;
  logic               xin;
  logic               overlap;
  logic               pat_load;
  logic [PAT_LEN-1:0] pat_in;
  logic               zout;
`ifdef SEQDET_COUNT_EN
  logic [CNT_W-1:0]   match_cnt;
`endif

  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("seq_detector_mealy_if: CNT_W must be at least 1");
  end

  modport master (
    output en,
    output xin,
    output overlap,
    output pat_load,
    output pat_in,
`ifdef SEQDET_COUNT_EN
    input  match_cnt,
`endif
    input  zout
  );

  modport slave (
    input  en,
    input  xin,
    input  overlap,
    input  pat_load,
    input  pat_in,
`ifdef SEQDET_COUNT_EN
    output match_cnt,
`endif
    output zout
  );

endinterface

// File: rtl/sat_counter.sv
// sat_counter
//   Saturating up-counter: counts inc pulses, sticks at all-ones, never wraps.
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous active-low reset (count cleared to 0)
//     inc    count enable for this edge
//     count  current count
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (inc && (count_q != {WIDTH{1'b1}})) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/seq_detector_mealy.sv
// seq_detector_mealy
//   Parametrised Mealy serial-pattern detector. Shifts qualified bits into a
//   history register and raises zout in the same cycle the final pattern bit
//   is presented. Pattern is reloadable at run time; overlap selects whether
//   history survives a match.
//   Optional feature macro: SEQDET_COUNT_EN -- when defined, a saturating
//   match counter (sat_counter) drives bus.match_cnt.
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous active-low reset
//     bus    seq_detector_mealy_if.slave (en, xin, overlap, pat_load,
//            pat_in in; zout, match_cnt out)
module seq_detector_mealy
  import seq_detector_pkg::*;
#(
  parameter int                 PAT_LEN = PAT_LEN_DEFAULT,
  parameter logic [PAT_LEN-1:0] PATTERN = PATTERN_DEFAULT,
  parameter int                 CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  seq_detector_mealy_if.slave  bus
);

  if ((PAT_LEN < PAT_LEN_MIN) || (PAT_LEN > PAT_LEN_MAX)) begin : g_bad_pat_len
    $error("seq_detector_mealy: PAT_LEN out of range");
  end

  localparam int                FILL_W   = $clog2(PAT_LEN);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_LEN - 1);

  logic [PAT_LEN-1:0] pat_q;
  logic [PAT_LEN-2:0] hist_q;
  logic [FILL_W-1:0]  fill_q;
  fill_state_e        state_q;

  // Candidate window: stored history followed by the bit on the wire now.
  logic [PAT_LEN-1:0] window;
  logic               hit;

  assign window = {hist_q, bus.xin};

  // reset is included so zout is forced low for the whole reset pulse,
  // independent of when the asynchronous clear of the registers settles.
  assign hit = reset & bus.en & ~bus.pat_load & (state_q == ARMED) &
               (window == pat_q);

  assign bus.zout = hit;

  // state_q mirrors fill_q reaching FILL_MAX so the compare path does not
  // need a magnitude comparator on the counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pat_q   <= PATTERN;
      hist_q  <= '0;
      fill_q  <= '0;
      state_q <= FILL;
    end else if (bus.pat_load) begin
      pat_q   <= bus.pat_in;
      hist_q  <= '0;
      fill_q  <= '0;
      state_q <= FILL;
    end else if (bus.en) begin
      if (hit && !bus.overlap) begin
        // Non-overlapping: a match consumes its bits, start refilling.
        hist_q  <= '0;
        fill_q  <= '0;
        state_q <= FILL;
      end else begin
        hist_q <= window[PAT_LEN-2:0];
        if (state_q == FILL) begin
          fill_q <= fill_q + 1'b1;
          if (fill_q == FILL_MAX - 1'b1) begin
            state_q <= ARMED;
          end
        end
      end
    end
  end

`ifdef SEQDET_COUNT_EN
  sat_counter #(
    .WIDTH (CNT_W)
  ) u_match_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (hit),
    .count (bus.match_cnt)
  );
`endif

endmodule

// File: doc/seq_detector_mealy.md
# seq_detector_mealy

Parametrised Mealy serial-pattern detector, the next generation of the team's fixed 4-state `fsm_mealy` detector. Watches a 1-bit serial stream `xin` qualified by `en` and asserts `zout` combinationally in the same cycle that the last bit of the target pattern arrives. Adds runtime-loadable pattern, overlap/non-overlap selection and an optional saturating match counter. Sits on the serial input path ahead of the framing logic.

## Interface
- `PAT_LEN`, 4: pattern length in bits, 2..16.
- `PATTERN`, 4'b1011: reset value of the pattern register, `PAT_LEN` bits; MSB = first bit received.
- `CNT_W`, 8: match counter width (only with `SEQDET_COUNT_EN`).
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset (asserted at 0).
- `en`  in  1  input-bit qualifier; 0 = bubble, state frozen.
- `xin`  in  1  serial data bit.
- `overlap`  in  1  1 = overlapping matches allowed; 0 = history cleared after each match.
- `pat_load`  in  1  load `pat_in` into pattern register this edge.
- `pat_in`  in  PAT_LEN  new pattern.
- `zout`  out  1  Mealy match output.
- `match_cnt`  out  CNT_W  saturating match count (only with `SEQDET_COUNT_EN`).

## Operation
- Registered state: `pat_q` (PAT_LEN), `hist_q` (PAT_LEN-1, last received bits, newest in LSB), `fill_q` (0..PAT_LEN-1, valid bits in `hist_q`), `match_cnt`.
- FSM on `fill_q`: FILL (`fill_q` < PAT_LEN-1), ARMED (`fill_q` = PAT_LEN-1).
- `zout` = `reset` & `en` & ~`pat_load` & ARMED & ({`hist_q`,`xin`} == `pat_q`). Purely combinational from `en`, `xin`, `pat_load`, `reset` and registered state.
- Rising edge, `en`=1, `pat_load`=0:
  - `hist_q` <= {`hist_q`[PAT_LEN-3:0], `xin`}; `fill_q` increments, saturating at PAT_LEN-1.
  - If `zout`=1 and `overlap`=0: `fill_q` <= 0 (return to FILL); `hist_q` contents don't-care.
  - If `zout`=1 and `overlap`=1: shift normally, stay ARMED.
- `en`=0, `pat_load`=0: all state holds, `zout`=0.
- `pat_load`=1 (any `en`): `pat_q` <= `pat_in`; `fill_q` <= 0; `hist_q` <= 0; `xin` discarded; `zout`=0; counter holds.
- `overlap` is sampled every cycle; changing it mid-stream affects only the next match.

## Timing
- Latency: zero cycles, since `zout` is high in the cycle the final pattern bit is presented.
- First possible match is the PAT_LEN-th qualified bit after reset or `pat_load`.
- Reset values (`reset`=0, asynchronous): `pat_q`=`PATTERN`, `hist_q`=0, `fill_q`=0, `match_cnt`=0, `zout`=0 (forced while `reset` is low).
- Reset mid-sequence discards all partial history; deassertion is synchronised externally.
- `match_cnt` increments on the edge where `zout`=1 and saturates at 2^CNT_W-1. It does not wrap.

## Configuration
- `SEQDET_COUNT_EN` defined: `match_cnt` port and counter register present.
- Not defined: port and register absent; detection behaviour otherwise identical.

## Structure
- Shared package `seq_detector_pkg`: FSM state encoding (`FILL`, `ARMED`), the `PAT_LEN` bound constants (2 and 16), and the default-pattern constant.
- One sub-module: `sat_counter` (parameter width, `inc` input, saturating, async active-low reset), instantiated under `SEQDET_COUNT_EN`.
- Top level holds the history, fill FSM and compare logic.

## Test plan
- Defaults, `overlap`=1, `en`=1, stream 1,0,1,1,0,1,1 -> `zout`=1 on bits 4 and 7 only; `match_cnt`=2.
- Same stream, `overlap`=0 -> `zout`=1 on bit 4 only; bits 5–7 re-fill, no match; `match_cnt`=1.
- Stream 1,0,1, then `en`=0 for 2 cycles with `xin`=0, then `en`=1 and `xin`=1 -> `zout`=0 during the bubble and `zout`=1 on the resumed bit.
- Stream 1,0,1, then `reset` low for 1 cycle, then 1 -> `zout`=0 and `fill_q`=1; a full 1,0,1,1 is needed to match.
- `pat_load`=1 with `pat_in`=4'b0110, then stream 0,1,1,0 -> `zout`=0 during the load cycle and `zout`=1 on the 4th bit; old pattern 1011 no longer matches.
- `CNT_W`=2, `overlap`=1, stream 1,0,1,1,0,1,1,0,1,1,0,1,1,0,1,1 (5 matches) -> `match_cnt` = 3 and holds at 3.
